// File: rtl/comp_job_dispatcher.sv
// comp_job_dispatcher: upstream sequencer for the 8-bit two's-complement stage.
// Takes one operand over a valid/ready stream, issues it to the stage with a
// one-cycle start pulse, waits for a rising edge of done and presents the
// {operand, result} pair downstream. One job in flight; completed jobs counted.
// Optional feature macro: DISPATCH_TIMEOUT_EN (bounded WAIT with error completion).
module comp_job_dispatcher #(
  parameter int DATA_W         = 8,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              c_start,
  output logic [DATA_W-1:0] c_in,
  input  logic [DATA_W-1:0] c_out,
  input  logic              c_done,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_orig,
  output logic [DATA_W-1:0] m_data,
  output logic              m_err,
  output logic [CNT_W-1:0]  job_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic                done_q_r;
  logic                done_edge_s;
  logic                timeout_s;
  logic                c_start_r;
  logic [DATA_W-1:0]   c_in_r;
  logic                m_valid_r;
  logic [DATA_W-1:0]   m_orig_r;
  logic [DATA_W-1:0]   m_data_r;
  logic                m_err_r;
  logic [CNT_W-1:0]    job_cnt_r;
  logic                busy_r;

  // A done level left high from the previous job must not complete a new one,
  // so completion is keyed on the rising edge only.
  assign done_edge_s = c_done && !done_q_r;

`ifdef DISPATCH_TIMEOUT_EN
  localparam int WC_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [WC_W-1:0] wait_cnt_r;

  // Count cycles spent in WAIT; cleared while issuing so each job starts at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wait_cnt_r <= {WC_W{1'b0}};
    end else if (state_r == ISSUE) begin
      wait_cnt_r <= {WC_W{1'b0}};
    end else if (state_r == WAIT) begin
      wait_cnt_r <= wait_cnt_r + WC_W'(1'b1);
    end else begin
      wait_cnt_r <= wait_cnt_r;
    end
  end

  assign timeout_s = (state_r == WAIT) && (wait_cnt_r == WC_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int timeout_unused = TIMEOUT_CYCLES;
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic for the single-job sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (s_valid) state_s = ISSUE;
        else         state_s = IDLE;
      end
      ISSUE: state_s = WAIT;
      WAIT: begin
        if (done_edge_s || timeout_s) state_s = HOLD;
        else                          state_s = WAIT;
      end
      HOLD: begin
        if (m_ready) state_s = IDLE;
        else         state_s = HOLD;
      end
      default: state_s = IDLE;
    endcase
  end

  // Registered datapath: operand capture, start pulse, result capture, counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q_r  <= 1'b0;
      c_start_r <= 1'b0;
      c_in_r    <= {DATA_W{1'b0}};
      m_valid_r <= 1'b0;
      m_orig_r  <= {DATA_W{1'b0}};
      m_data_r  <= {DATA_W{1'b0}};
      m_err_r   <= 1'b0;
      job_cnt_r <= {CNT_W{1'b0}};
      busy_r    <= 1'b0;
    end else begin
      done_q_r  <= c_done;
      c_start_r <= (state_r == IDLE) && s_valid;
      busy_r    <= (state_s != IDLE);
      case (state_r)
        IDLE: begin
          if (s_valid) c_in_r <= s_data;
        end
        WAIT: begin
          // A done edge coinciding with the timeout takes priority.
          if (done_edge_s) begin
            m_data_r  <= c_out;
            m_orig_r  <= c_in_r;
            m_err_r   <= 1'b0;
            m_valid_r <= 1'b1;
          end else if (timeout_s) begin
            m_data_r  <= {DATA_W{1'b0}};
            m_orig_r  <= c_in_r;
            m_err_r   <= 1'b1;
            m_valid_r <= 1'b1;
          end
        end
        HOLD: begin
          if (m_ready) begin
            m_valid_r <= 1'b0;
            job_cnt_r <= job_cnt_r + CNT_W'(1'b1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign s_ready = (state_r == IDLE);
  assign c_start = c_start_r;
  assign c_in    = c_in_r;
  assign m_valid = m_valid_r;
  assign m_orig  = m_orig_r;
  assign m_data  = m_data_r;
  assign m_err   = m_err_r;
  assign job_cnt = job_cnt_r;
  assign busy    = busy_r;

endmodule

// File: tb/tb_comp_job_dispatcher.sv
// Directed self-checking bench for comp_job_dispatcher. The stage is modelled
// inline by the job task; expected results are hand-computed constants.
module tb_comp_job_dispatcher;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  s_data = 8'h00;
  logic        c_start;
  logic [7:0]  c_in;
  logic [7:0]  c_out = 8'h00;
  logic        c_done = 1'b0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_orig;
  logic [7:0]  m_data;
  logic        m_err;
  logic [15:0] job_cnt;
  logic        busy;

  int checks = 0;
  int failures = 0;

  comp_job_dispatcher #(.DATA_W(8), .CNT_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .c_start(c_start), .c_in(c_in), .c_out(c_out), .c_done(c_done),
    .m_valid(m_valid), .m_ready(m_ready), .m_orig(m_orig), .m_data(m_data),
    .m_err(m_err), .job_cnt(job_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; s_valid = 1'b0; m_ready = 1'b0; c_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One complete job: handshake, start pulse, stage latency, result, optional stall, accept.
  task automatic run_job(input logic [7:0] op, input logic [7:0] exp_res, input int lat,
                         input bit level, input int stall, input bit keep,
                         input logic [7:0] nxt, input logic [15:0] exp_cnt);
    int n;
    s_valid = 1'b1; s_data = op;
    n = 0;
    do begin @(negedge clk); n++; end while (!c_start && n < 20);
    checks++;
    if (c_start !== 1'b1 || n != 1) begin
      failures++; $display("FAIL start_latency op=%h got cycles=%0d start=%b required cycles=1", op, n, c_start);
    end
    checks++;
    if (c_in !== op) begin
      failures++; $display("FAIL c_in_capture got=%h required=%h", c_in, op);
    end
    if (keep) s_data = nxt;
    else      s_valid = 1'b0;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      checks++;
      if (c_start !== 1'b0 || c_in !== op || m_valid !== 1'b0 || s_ready !== 1'b0 || busy !== 1'b1) begin
        failures++;
        $display("FAIL wait_phase op=%h got start=%b c_in=%h m_valid=%b s_ready=%b busy=%b required 0/%h/0/0/1",
                 op, c_start, c_in, m_valid, s_ready, busy, op);
      end
    end
    if (c_done) begin
      c_done = 1'b0;
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b0) begin
        failures++; $display("FAIL stale_done got m_valid=%b required=0", m_valid);
      end
    end
    c_out = ~c_in + 8'd1;
    c_done = 1'b1;
    @(negedge clk);
    if (!level) c_done = 1'b0;
    checks++;
    if (m_valid !== 1'b1 || m_orig !== op || m_data !== exp_res || m_err !== 1'b0 || s_ready !== 1'b0) begin
      failures++;
      $display("FAIL result got valid=%b orig=%h data=%h err=%b s_ready=%b required 1/%h/%h/0/0",
               m_valid, m_orig, m_data, m_err, s_ready, op, exp_res);
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_orig !== op || m_data !== exp_res || s_ready !== 1'b0) begin
        failures++;
        $display("FAIL hold_stable cycle=%0d got valid=%b orig=%h data=%h s_ready=%b required 1/%h/%h/0",
                 i, m_valid, m_orig, m_data, s_ready, op, exp_res);
      end
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || job_cnt !== exp_cnt || s_ready !== 1'b1 || busy !== 1'b0) begin
      failures++;
      $display("FAIL accept got valid=%b job_cnt=%0d s_ready=%b busy=%b required 0/%0d/1/0",
               m_valid, job_cnt, s_ready, busy, exp_cnt);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || c_start !== 1'b0 || c_in !== 8'h00 || m_valid !== 1'b0 || m_orig !== 8'h00 ||
        m_data !== 8'h00 || m_err !== 1'b0 || job_cnt !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values got s_ready=%b start=%b c_in=%h valid=%b orig=%h data=%h err=%b cnt=%0d busy=%b",
               s_ready, c_start, c_in, m_valid, m_orig, m_data, m_err, job_cnt, busy);
    end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    run_job(8'h05, 8'hFB, 3, 1'b0, 0, 1'b0, 8'h00, 16'd1);
  endtask

  task automatic test_back_to_back();
    apply_reset();
    run_job(8'h00, 8'h00, 3, 1'b0, 0, 1'b1, 8'h01, 16'd1);
    run_job(8'h01, 8'hFF, 3, 1'b0, 0, 1'b1, 8'h80, 16'd2);
    run_job(8'h80, 8'h80, 3, 1'b0, 0, 1'b0, 8'h00, 16'd3);
  endtask

  task automatic test_stall();
    run_job(8'h7F, 8'h81, 2, 1'b0, 10, 1'b0, 8'h00, 16'd4);
  endtask

  task automatic test_level_done();
    run_job(8'h04, 8'hFC, 3, 1'b1, 0, 1'b0, 8'h00, 16'd5);
    run_job(8'h02, 8'hFE, 3, 1'b1, 0, 1'b0, 8'h00, 16'd6);
    c_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    s_valid = 1'b1; s_data = 8'h10;
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || c_start !== 1'b0 || c_in !== 8'h00 || m_valid !== 1'b0 || m_orig !== 8'h00 ||
        m_data !== 8'h00 || m_err !== 1'b0 || job_cnt !== 16'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_values got s_ready=%b start=%b c_in=%h valid=%b orig=%h data=%h err=%b cnt=%0d busy=%b",
               s_ready, c_start, c_in, m_valid, m_orig, m_data, m_err, job_cnt, busy);
    end
    reset = 1'b1;
    @(negedge clk);
    run_job(8'h03, 8'hFD, 3, 1'b0, 0, 1'b0, 8'h00, 16'd1);
  endtask

  task automatic test_timeout();
    int n;
    s_valid = 1'b1; s_data = 8'h33;
    @(negedge clk);
    s_valid = 1'b0;
    checks++;
    if (c_start !== 1'b1) begin
      failures++; $display("FAIL timeout_start got=%b required=1", c_start);
    end
`ifdef DISPATCH_TIMEOUT_EN
    n = 0;
    do begin @(negedge clk); n++; end while (!m_valid && n < 40);
    checks++;
    if (m_valid !== 1'b1 || n != 9 || m_err !== 1'b1 || m_data !== 8'h00 || m_orig !== 8'h33) begin
      failures++;
      $display("FAIL timeout_result got valid=%b cycles=%0d err=%b data=%h orig=%h required 1/9/1/00/33",
               m_valid, n, m_err, m_data, m_orig);
    end
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
    checks++;
    if (m_valid !== 1'b0 || job_cnt !== 16'd2 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL timeout_accept got valid=%b cnt=%0d s_ready=%b required 0/2/1", m_valid, job_cnt, s_ready);
    end
`else
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (busy !== 1'b1 || m_valid !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      failures++; $display("FAIL no_timeout_busy got bad_cycles=%0d required=0", n);
    end
    apply_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || s_ready !== 1'b1) begin
      failures++; $display("FAIL no_timeout_recover got busy=%b s_ready=%b required 0/1", busy, s_ready);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_level_done();
    test_reset_mid();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
